prime_uart_tx: RTL

Downstream display stage for primogen results. Accepts one unsigned prime per go/ready handshake and converts it to decimal with an iterative double-dabble. Transmits the digits, leading zeros suppressed, followed by CR LF as 8N1 UART frames on a single tx pin. On icestick it sits beside the LED logic and streams each new prime to the FTDI UART.

---
 rtl/prime_uart_tx.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/prime_uart_tx.sv
// rtl/prime_uart_tx.sv - decimal UART printer for primogen results
//
// Purpose: accepts one unsigned value per go/ready handshake, converts it to
// BCD with an iterative double-dabble (one shift per clock), then sends the
// significant digits MSB-first as ASCII followed by CR LF on a UART line.
// Frames are back-to-back: start bit, 8 data bits LSB-first, stop bit.
//
// Build option: define PRIME_UART_PARITY_EN for 8E1 frames, which insert an
// even-parity bit between data bit 7 and the stop bit. Without it, frames are 8N1.
//
// Parameters:
//   WIDTH_LOG    value width W = 1 << WIDTH_LOG
//   DIGITS       BCD digit count, 10^DIGITS > 2^W
//   CLKS_PER_BIT clocks per UART bit, >= 2
//
// Ports:
//   clk    system clock, rising edge
//   rst    asynchronous active-low reset
//   go     print request, honoured only while ready = 1
//   val    value to print, sampled on the accepting edge
//   ready  1 = idle and able to accept go
//   tx     UART line, idle high

module prime_uart_tx #(
  parameter int WIDTH_LOG    = 4,
  parameter int DIGITS       = 5,
  parameter int CLKS_PER_BIT = 104
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        go,
  input  logic [(1<<WIDTH_LOG)-1:0]   val,
  output logic                        ready,
  output logic                        tx
);

  localparam int W      = 1 << WIDTH_LOG;
  localparam int BCD_W  = 4 * DIGITS;
  localparam int CONV_W = $clog2(W + 1);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int SEL_W  = $clog2(DIGITS + 2);
  localparam int BIT_W  = 4;
`ifdef PRIME_UART_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  typedef enum logic [1:0] {IDLE, CONV, SEND, DONE} state_t;

  state_t                  state;
  state_t                  state_next;

  logic [W-1:0]            bin;
  logic [BCD_W-1:0]        bcd;
  logic [BCD_W-1:0]        bcd_adj;
  logic [BCD_W-1:0]        bcd_step;
  logic [CONV_W-1:0]       conv_cnt;
  logic [BAUD_W-1:0]       baud_cnt;
  logic [BIT_W-1:0]        bit_cnt;
  // Byte selector: 0..DIGITS-1 picks a BCD nibble, DIGITS is CR, DIGITS+1 is LF.
  logic [SEL_W-1:0]        sel;
  logic [SEL_W-1:0]        first_sel;
  logic [SEL_W-1:0]        sel_adv;
  logic [3:0]              nib;
  logic [7:0]              tx_byte;
  logic [FRAME_BITS-1:0]   frame;
  logic                    conv_done;
  logic                    baud_end;
  logic                    bit_last;
  logic                    last_byte;

  // Conversion runs W shift cycles; the extra cycle with conv_cnt == W picks
  // the first digit from the settled BCD value, which puts the start bit
  // exactly W+1 cycles after the accept edge.
  assign conv_done = (conv_cnt == CONV_W'(W));
  assign baud_end  = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
  assign bit_last  = (bit_cnt == BIT_W'(FRAME_BITS - 1));
  assign last_byte = (sel == SEL_W'(DIGITS + 1));

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
    bcd_step = (bcd_adj << 1) | BCD_W'(bin[W-1]);
  end

  // The highest nonzero nibble wins; an all-zero value leaves nibble 0 so "0" prints.
  always_comb begin
    first_sel = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] != 4'd0) begin
        first_sel = SEL_W'(i);
      end
    end
  end

  // Digits count down toward nibble 0, then jump to CR and step to LF.
  always_comb begin
    if (sel == '0) begin
      sel_adv = SEL_W'(DIGITS);
    end else if (sel < SEL_W'(DIGITS)) begin
      sel_adv = sel - SEL_W'(1);
    end else begin
      sel_adv = sel + SEL_W'(1);
    end
  end

  always_comb begin
    nib = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (sel == SEL_W'(i)) begin
        nib = bcd[4*i +: 4];
      end
    end
    if (sel == SEL_W'(DIGITS)) begin
      tx_byte = 8'h0D;
    end else if (sel == SEL_W'(DIGITS + 1)) begin
      tx_byte = 8'h0A;
    end else begin
      tx_byte = {4'h3, nib};
    end
`ifdef PRIME_UART_PARITY_EN
    frame = {1'b1, ^tx_byte, tx_byte, 1'b0};
`else
    frame = {1'b1, tx_byte, 1'b0};
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ready and tx decode straight from state so reset forces both at once.
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    tx         = 1'b1;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (go) begin
          state_next = CONV;
        end
      end
      CONV: begin
        if (conv_done) begin
          state_next = SEND;
        end
      end
      SEND: begin
        tx = frame[bit_cnt];
        if (baud_end && bit_last && last_byte) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bin      <= '0;
      bcd      <= '0;
      conv_cnt <= '0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      sel      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            bin      <= val;
            bcd      <= '0;
            conv_cnt <= '0;
          end
        end
        CONV: begin
          if (conv_done) begin
            sel      <= first_sel;
            baud_cnt <= '0;
            bit_cnt  <= '0;
          end else begin
            bcd      <= bcd_step;
            bin      <= bin << 1;
            conv_cnt <= conv_cnt + CONV_W'(1);
          end
        end
        SEND: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_last) begin
              bit_cnt <= '0;
              sel     <= sel_adv;
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
